// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
//   Receive end of the LIF spike link. Counts rising edges of spike_in over
//   back-to-back windows of WINDOW_LEN cycles and presents each window's count
//   on a valid/ready output port.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   en           1 = decoding active; 0 = window logic held cleared
//   spike_in     spike level from the neuron; only rising edges count
//   rate_ready   downstream accepts rate_out this cycle
//   clr_ovr      synchronous clear of the overrun flag
//   rate_out     spike count of the last completed window
//   rate_sat     that window's count hit the counter ceiling
//   rate_valid   rate_out holds an unconsumed result
//   overrun      sticky: an unconsumed result was overwritten
//   busy         a window is in progress
module spike_rate_decoder #(
  parameter int WINDOW_LEN = 256,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike_in,
  input  logic             rate_ready,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_sat,
  output logic             rate_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int                TMR_W    = $clog2(WINDOW_LEN);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] count;
  logic             spike_q;

  logic             edge_det;
  logic [CNT_W-1:0] cnt_next;
  logic             win_close;
  logic             set_ovr;

  // spike_q is held at 0 while idle, so a level already high on the first
  // enabled cycle is seen as a fresh edge in window cycle 0.
  assign edge_det  = en & spike_in & ~spike_q;
  assign cnt_next  = (edge_det && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
  // The timer only reaches its last value while counting (WINDOW_LEN >= 2),
  // but the state term keeps the intent explicit.
  assign win_close = en & (state_q == S_COUNT) & (timer == TMR_LAST);
  assign set_ovr   = win_close & rate_valid & ~rate_ready;
  assign busy      = (state_q == S_COUNT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: the first enabled cycle is already window cycle 0, so the
  // window logic below runs off en directly; state only tracks busy.
  always_comb begin
    state_d = state_q;
    if (en) state_d = S_COUNT;
    else    state_d = S_IDLE;
  end

  // Window timer, edge counter and edge-detect register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      count   <= '0;
      spike_q <= 1'b0;
    end else if (!en) begin
      // Dropping en discards any partial window.
      timer   <= '0;
      count   <= '0;
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_in;
      if (win_close) begin
        // Next window starts on the following cycle with no gap.
        timer <= '0;
        count <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
        count <= cnt_next;
      end
    end
  end

  // Result register and handshake. These are independent of en so a pending
  // result can still be consumed while decoding is paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_out   <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
    end else if (win_close) begin
      // A close always wins over a same-cycle transfer: valid stays high.
      rate_out   <= cnt_next;
      rate_sat   <= (cnt_next == CNT_MAX);
      rate_valid <= 1'b1;
    end else if (rate_valid && rate_ready) begin
      rate_valid <= 1'b0;
    end
  end

  // Sticky overrun; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (set_ovr) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule
